sort_unique_engine: RTL and testbench
=====================================

Name: sort_unique_engine

Overview:
Parametrised buffer engine that loads up to DEPTH words over a valid/ready stream and sorts them in place by selection sort. It can optionally compact the result to unique values, then drains the result over a second valid/ready stream. It is the general successor to the fixed 8-entry sort/unique-extract datapath. It adds runtime ascending/descending order, a unique/keep-all mode, a variable element count, and stream handshakes in place of hard-wired load constants.

Parameters:
WIDTH, 32, data word width in bits; comparisons are unsigned.
DEPTH, 16, buffer entries; must be >= 2.
CNT_W, $clog2(DEPTH+1), width of the element-count and result-count fields.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  load beat valid.
in_ready  output  1  load beat accepted when in_valid && in_ready.
in_data  input  WIDTH  load word.
in_last  input  1  final load beat; an accepted beat with in_last=1 acts as start.
start  input  1  begin processing the words loaded so far; sampled only in IDLE.
desc  input  1  0 = ascending, 1 = descending; latched at start.
uniq  input  1  1 = drop duplicates, 0 = keep all; latched at start.
busy  output  1  high in SORT, DEDUP and DRAIN.
done  output  1  one-cycle pulse after the final out beat, or after a start with zero elements.
count  output  CNT_W  result length; held until the next start.
out_valid  output  1  result beat valid.
out_ready  input  1  result beat consumed when out_valid && out_ready.
out_data  output  WIDTH  result word.
out_last  output  1  high with the final result beat.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; n, i, j, sel, m, k, r = 0; all memory words = 0; busy, done, count, out_valid, out_data and out_last all = 0. Reset mid-operation aborts without a done pulse and discards the loaded data.
- States: IDLE, SORT, SWAP, DEDUP, DRAIN.
- IDLE:
  - in_ready = (n < DEPTH). An accepted beat writes mem[n] and increments n.
  - When n = DEPTH, in_ready = 0 and further beats stall.
  - A trigger is start=1 or an accepted beat with in_last=1. A beat accepted in the trigger cycle is included in n.
  - On trigger with final n >= 2: go to SORT with i=0, j=1, sel=0.
  - On trigger with n = 1: go directly to DEDUP.
  - On trigger with n = 0: count=0, done pulses next cycle, stay in IDLE.
- SORT (one compare per cycle):
  - better = desc ? mem[j] > mem[sel] : mem[j] < mem[sel]. If better, sel <= j.
  - j increments; when j = n-1, the next state is SWAP.
- SWAP (1 cycle):
  - Exchange mem[i] and mem[sel]; this is a no-op when sel = i.
  - Then i++. If i = n-2 before the increment, go to DEDUP; otherwise go to SORT with j=i+2, sel=i+1.
- Sort latency: n(n-1)/2 compare cycles + (n-1) swap cycles. For n=8 that is 35 cycles. Equal keys never swap past each other unnecessarily (strict compare).
- DEDUP:
  - Start with k=1, m=1. One cycle per m, for m = 1..n-1.
  - If uniq=0 or mem[m] != mem[k-1]: mem[k] <= mem[m] and k++.
  - When m = n-1 has been processed, set count <= final k and go to DRAIN with r=0.
  - For uniq=0, count = n. Dedup takes n-1 cycles; for n=1 it is a single pass-through cycle.
- DRAIN:
  - out_valid=1, out_data=mem[r], out_last=(r == count-1).
  - r increments on each handshake. out_data is stable while out_valid && !out_ready.
  - After the last handshake: out_valid=0, done pulses 1 cycle, n=0, state=IDLE.
- in_ready = 0 outside IDLE. start is ignored outside IDLE.

Decomposition:
- Shared package: the state encoding constants (IDLE, SORT, SWAP, DEDUP, DRAIN) and the mode bit positions (desc, uniq).
- One sub-module, sue_regfile: a DEPTH x WIDTH array with asynchronous active-low clear, two combinational read ports and two synchronous write ports, the second used only for SWAP.
- The FSM, counters and comparator stay in sort_unique_engine.

Test Plan:
- Load 8,1,8,1,8,1,8,1 (in_last on the 8th beat), desc=0, uniq=1 -> SORT lasts 35 cycles; out = 1, 8; count=2; out_last on 8; done pulses once.
- Same data, desc=1, uniq=0 -> out = 8,8,8,8,1,1,1,1; count=8.
- 17 beats offered with DEPTH=16 -> in_ready drops after the 16th beat; the 17th is held. start -> 16 sorted words out, and the 17th beat is accepted in IDLE afterwards.
- start with no beats loaded -> no out_valid; count=0; done pulses the cycle after start.
- Load 5,3,5,0,3 with desc=0, uniq=1, and out_ready toggling 1,0,0,1 -> out = 0,3,5 with data held during stalls; count=3.
- Assert rst in the middle of SORT -> all outputs go to 0 immediately; no done. Reload 2,1 -> out 1,2.

Source files
------------

// File: rtl/sort_unique_engine_pkg.sv
// Shared definitions for the sort/unique engine: FSM encoding and mode-bit layout.
package sort_unique_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SORT  = 3'd1,
        S_SWAP  = 3'd2,
        S_DEDUP = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam int MODE_DESC = 0;
    localparam int MODE_UNIQ = 1;
    localparam int MODE_W    = 2;

endpackage

// File: rtl/sue_regfile.sv
// DEPTH x WIDTH word store with two combinational read ports and two write ports.
module sue_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic             wa_en,
    input  logic [AW-1:0]    wa_addr,
    input  logic [WIDTH-1:0] wa_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

    // Port b only fires together with port a during a swap, where equal
    // addresses carry equal data, so write ordering does not matter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
        end else begin
            if (wa_en) mem[wa_addr] <= wa_data;
            if (wb_en) mem[wb_addr] <= wb_data;
        end
    end

endmodule

// File: rtl/sort_unique_engine.sv
// Stream-loaded buffer that selection-sorts in place, optionally drops duplicates, then drains.
module sort_unique_engine
    import sort_unique_engine_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             start,
    input  logic             desc,
    input  logic             uniq,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t            state;
    logic [CNT_W-1:0]  n, i, j, sel, m, k, r;
    logic [MODE_W-1:0] mode;

    logic [AW-1:0]     ra_addr, rb_addr, wa_addr, wb_addr;
    logic [WIDTH-1:0]  ra_data, rb_data, wa_data, wb_data;
    logic              wa_en, wb_en;
    logic              acc, trig, better, keep;
    logic [CNT_W-1:0]  n_next, k_next, km1;

    assign in_ready = (state == S_IDLE) && (n < CNT_W'(DEPTH));
    assign acc      = in_valid && in_ready;
    assign trig     = (state == S_IDLE) && (start || (acc && in_last));
    assign n_next   = n + CNT_W'(acc);
    assign km1      = k - ONE;

    // Strict compare keeps equal keys from swapping needlessly.
    assign better = mode[MODE_DESC] ? (ra_data > rb_data) : (ra_data < rb_data);
    assign keep   = (m < n) && (!mode[MODE_UNIQ] || (ra_data != rb_data));
    assign k_next = k + CNT_W'(keep);

    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DRAIN);
    assign out_last  = out_valid && (r == count - ONE);
    assign out_data  = out_valid ? ra_data : '0;

    always_comb begin
        ra_addr = '0;
        rb_addr = '0;
        wa_en   = 1'b0;
        wa_addr = n[AW-1:0];
        wa_data = in_data;
        wb_en   = 1'b0;
        wb_addr = sel[AW-1:0];
        wb_data = ra_data;
        case (state)
            S_IDLE:  wa_en = acc;
            S_SORT: begin
                ra_addr = j[AW-1:0];
                rb_addr = sel[AW-1:0];
            end
            S_SWAP: begin
                ra_addr = i[AW-1:0];
                rb_addr = sel[AW-1:0];
                wa_en   = 1'b1;
                wa_addr = i[AW-1:0];
                wa_data = rb_data;
                wb_en   = 1'b1;
            end
            S_DEDUP: begin
                ra_addr = m[AW-1:0];
                rb_addr = km1[AW-1:0];
                wa_en   = keep;
                wa_addr = k[AW-1:0];
                wa_data = ra_data;
            end
            S_DRAIN: ra_addr = r[AW-1:0];
            default: ;
        endcase
    end

    sue_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ra_addr),
        .ra_data (ra_data),
        .rb_addr (rb_addr),
        .rb_data (rb_data),
        .wa_en   (wa_en),
        .wa_addr (wa_addr),
        .wa_data (wa_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            n     <= '0;
            i     <= '0;
            j     <= '0;
            sel   <= '0;
            m     <= '0;
            k     <= '0;
            r     <= '0;
            mode  <= '0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    n <= n_next;
                    if (trig) begin
                        mode[MODE_DESC] <= desc;
                        mode[MODE_UNIQ] <= uniq;
                        if (n_next >= TWO) begin
                            state <= S_SORT;
                            i     <= '0;
                            j     <= ONE;
                            sel   <= '0;
                        end else if (n_next == ONE) begin
                            state <= S_DEDUP;
                            k     <= ONE;
                            m     <= ONE;
                        end else begin
                            count <= '0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_SORT: begin
                    if (better) sel <= j;
                    if (j == n - ONE) state <= S_SWAP;
                    else              j     <= j + ONE;
                end
                S_SWAP: begin
                    if (i == n - TWO) begin
                        state <= S_DEDUP;
                        k     <= ONE;
                        m     <= ONE;
                    end else begin
                        i     <= i + ONE;
                        j     <= i + TWO;
                        sel   <= i + ONE;
                        state <= S_SORT;
                    end
                end
                S_DEDUP: begin
                    k <= k_next;
                    m <= m + ONE;
                    if (m >= n - ONE) begin
                        count <= k_next;
                        r     <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r == count - ONE) begin
                            done  <= 1'b1;
                            n     <= '0;
                            state <= S_IDLE;
                        end else begin
                            r <= r + ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_unique_engine.sv
// Directed table-driven bench for sort_unique_engine plus hand sequences for stalls, overflow and reset.
module tb_sort_unique_engine;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk, rst;
    logic             in_valid, in_ready, in_last, start, desc, uniq;
    logic [WIDTH-1:0] in_data;
    logic             busy, done, out_valid, out_ready, out_last;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] out_data;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct packed {
        logic [4:0]        n;
        logic              desc;
        logic              uniq;
        logic [4:0]        cnt;
        logic [15:0][31:0] din;
        logic [15:0][31:0] dout;
    } vec_t;

    vec_t vecs[7];
    vec_t v;

    sort_unique_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .start     (start),
        .desc      (desc),
        .uniq      (uniq),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Offers every word of v; the final beat carries in_last and so triggers.
    task automatic load(input vec_t lv);
        for (int b = 0; b < int'(lv.n); b++) begin
            @(negedge clk);
            chk("in_ready_load", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = lv.din[b];
            in_last  = (b == int'(lv.n) - 1);
            desc     = lv.desc;
            uniq     = lv.uniq;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at the first negedge after the trigger edge.
    task automatic wait_out(input vec_t lv);
        int cyc, nn, exp_lat;
        nn  = int'(lv.n);
        cyc = 1;
        exp_lat = 1 + nn * (nn - 1) / 2 + (nn - 1) + ((nn > 1) ? nn - 1 : 1);
        while (!out_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
    endtask

    task automatic drain(input vec_t lv, input logic [3:0] pat);
        int idx, cyc;
        idx = 0;
        cyc = 0;
        while (idx < int'(lv.cnt) && cyc < 500) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_data", out_data, lv.dout[idx]);
            chk("out_last", 32'(out_last), 32'(idx == int'(lv.cnt) - 1));
            out_ready = pat[cyc % 4];
            cyc++;
            if (out_ready) idx++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("out_valid_end", 32'(out_valid), 32'd0);
        chk("count", 32'(count), 32'(lv.cnt));
        chk("busy_end", 32'(busy), 32'd0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        start = 1'b0; desc = 1'b0; uniq = 1'b0; out_ready = 1'b0;

        for (int x = 0; x < 7; x++) vecs[x] = '0;
        // 8,1,8,1,... ascending unique -> 1,8
        vecs[0].n = 5'd8; vecs[0].uniq = 1'b1; vecs[0].cnt = 5'd2;
        for (int b = 0; b < 8; b++) vecs[0].din[b] = (b % 2 == 0) ? 32'd8 : 32'd1;
        vecs[0].dout[0] = 32'd1; vecs[0].dout[1] = 32'd8;
        // same data, descending keep-all
        vecs[1] = vecs[0]; vecs[1].desc = 1'b1; vecs[1].uniq = 1'b0; vecs[1].cnt = 5'd8;
        for (int b = 0; b < 8; b++) vecs[1].dout[b] = (b < 4) ? 32'd8 : 32'd1;
        // 5,3,5,0,3 ascending unique -> 0,3,5
        vecs[2].n = 5'd5; vecs[2].uniq = 1'b1; vecs[2].cnt = 5'd3;
        vecs[2].din[0] = 32'd5; vecs[2].din[1] = 32'd3; vecs[2].din[2] = 32'd5;
        vecs[2].din[3] = 32'd0; vecs[2].din[4] = 32'd3;
        vecs[2].dout[0] = 32'd0; vecs[2].dout[1] = 32'd3; vecs[2].dout[2] = 32'd5;
        // 7,9,7 descending unique -> 9,7
        vecs[3].n = 5'd3; vecs[3].desc = 1'b1; vecs[3].uniq = 1'b1; vecs[3].cnt = 5'd2;
        vecs[3].din[0] = 32'd7; vecs[3].din[1] = 32'd9; vecs[3].din[2] = 32'd7;
        vecs[3].dout[0] = 32'd9; vecs[3].dout[1] = 32'd7;
        // single element passes straight through
        vecs[4].n = 5'd1; vecs[4].cnt = 5'd1; vecs[4].din[0] = 32'd42; vecs[4].dout[0] = 32'd42;
        // 4,4 unique -> 4
        vecs[5].n = 5'd2; vecs[5].uniq = 1'b1; vecs[5].cnt = 5'd1;
        vecs[5].din[0] = 32'd4; vecs[5].din[1] = 32'd4; vecs[5].dout[0] = 32'd4;
        // unsigned ordering: FFFFFFFF is the largest
        vecs[6].n = 5'd3; vecs[6].cnt = 5'd3;
        vecs[6].din[0] = 32'hFFFF_FFFF; vecs[6].din[1] = 32'd0; vecs[6].din[2] = 32'd5;
        vecs[6].dout[0] = 32'd0; vecs[6].dout[1] = 32'd5; vecs[6].dout[2] = 32'hFFFF_FFFF;

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int x = 0; x < 7; x++) begin
            load(vecs[x]);
            wait_out(vecs[x]);
            drain(vecs[x], 4'b1111);
        end

        // out_ready pattern 1,0,0,1 with data held during stalls
        load(vecs[2]);
        wait_out(vecs[2]);
        drain(vecs[2], 4'b1001);

        // 17 beats offered: the 17th stalls until the engine returns to IDLE
        desc = 1'b0; uniq = 1'b0;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'(16 - b);
            in_last  = 1'b0;
        end
        @(negedge clk);
        chk("in_ready_full", 32'(in_ready), 32'd0);
        in_data = 32'd777;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        v = '0;
        v.n = 5'd16; v.cnt = 5'd16;
        for (int b = 0; b < 16; b++) v.dout[b] = 32'(b + 1);
        wait_out(v);
        drain(v, 4'b1111);
        // held beat went in at the done edge; start emits it alone
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        v = '0;
        v.n = 5'd1; v.cnt = 5'd1; v.dout[0] = 32'd777;
        wait_out(v);
        drain(v, 4'b1111);

        // reset in the middle of SORT
        load(vecs[0]);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        v = '0;
        v.n = 5'd2; v.cnt = 5'd2;
        v.din[0] = 32'd2; v.din[1] = 32'd1;
        v.dout[0] = 32'd1; v.dout[1] = 32'd2;
        load(v);
        wait_out(v);
        drain(v, 4'b1111);

        // start with nothing loaded
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_count", 32'(count), 32'd0);
        chk("empty_out_valid", 32'(out_valid), 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("empty_done_off", 32'(done), 32'd0);
        chk("empty_out_valid2", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
